// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO.
// Configurable data width, parity and stop bits; LSB-first serialisation.
module uart_tx_fifo #(
  parameter int unsigned cycles_per_bit = 3,
  parameter int unsigned data_bits      = 8,
  parameter int unsigned parity_mode    = 0,
  parameter int unsigned stop_bits      = 1,
  parameter int unsigned fifo_depth     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [data_bits-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_serial,
  output logic                          o_idle,
  output logic [$clog2(fifo_depth):0]   o_count
);

  localparam int unsigned AW  = $clog2(fifo_depth);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned CCW = $clog2(cycles_per_bit);
  localparam int unsigned BCW = $clog2(data_bits + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [data_bits-1:0] r_mem [fifo_depth];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_ready;
  logic                 r_idle;

  state_t               r_state;
  logic [CCW-1:0]       r_cyc;
  logic [BCW-1:0]       r_bit;
  logic [data_bits-1:0] r_shift;
  logic                 r_par;
  logic                 r_serial;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_last_stop;
  logic                 w_to_idle;
  logic                 w_par;
  logic [data_bits-1:0] w_head;
  logic [CW-1:0]        w_count_nxt;

  assign w_head      = r_mem[r_rptr];
  assign w_push      = i_valid && r_ready;
  assign w_bit_end   = (r_cyc == CCW'(cycles_per_bit - 1));
  assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit == BCW'(stop_bits - 1));
  // Pop whenever the line is free to start a new frame and data is waiting
  assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || w_last_stop);
  assign w_to_idle   = !w_pop && ((r_state == S_IDLE) || w_last_stop);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  // Parity of the whole popped word; odd mode inverts so the total ones count is odd
  assign w_par       = (parity_mode == 1) ? ~(^w_head) : (^w_head);

  assign o_ready  = r_ready;
  assign o_serial = r_serial;
  assign o_idle   = r_idle;
  assign o_count  = r_count;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // FIFO pointers, occupancy and derived status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
      r_idle  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < CW'(fifo_depth));
      r_idle  <= w_to_idle && (w_count_nxt == '0);
    end
  end

  // Frame sequencer: start, data LSB-first, optional parity, stop bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cyc    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_serial <= 1'b1;
    end else if (w_pop) begin
      r_state  <= S_START;
      r_shift  <= w_head;
      r_par    <= w_par;
      r_serial <= 1'b0;
      r_cyc    <= '0;
      r_bit    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cyc    <= '0;
          r_serial <= 1'b1;
        end
        S_START: begin
          if (w_bit_end) begin
            r_cyc    <= '0;
            r_state  <= S_DATA;
            r_serial <= r_shift[0];
          end else begin
            r_cyc <= r_cyc + CCW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            if (r_bit == BCW'(data_bits - 1)) begin
              r_bit <= '0;
              if (parity_mode != 0) begin
                r_state  <= S_PARITY;
                r_serial <= r_par;
              end else begin
                r_state  <= S_STOP;
                r_serial <= 1'b1;
              end
            end else begin
              r_bit    <= r_bit + BCW'(1);
              r_shift  <= r_shift >> 1;
              r_serial <= r_shift[1];
            end
          end else begin
            r_cyc <= r_cyc + CCW'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_cyc    <= '0;
            r_state  <= S_STOP;
            r_serial <= 1'b1;
          end else begin
            r_cyc <= r_cyc + CCW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            if (w_last_stop) begin
              r_bit   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_bit <= r_bit + BCW'(1);
            end
          end else begin
            r_cyc <= r_cyc + CCW'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule
